// File: rtl/tespar_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tespar_frame_ctrl
//
// Frame sequencer and symbol histogrammer for the TESPAR encoder path.
// Accepts one frame of signed 8-bit samples, forwards them to the encoder as
// registered strobed words, and counts the 5-bit alphabet symbols returned by
// the encoder into 32 saturating bins. At frame end the bins are streamed out
// one per handshake and each is cleared as it is read.
//
// Optional feature (compile-time macro TESPAR_SAT_FLAG_EN):
//   adds output sat_flag, set when any bin increment is blocked by saturation,
//   cleared when RUN is entered, held through DUMP so it can be sampled with
//   done.
//
// Ports:
//   clk, reset          single rising-edge clock, asynchronous active-high reset
//   start               frame start request, honoured only in IDLE
//   s_valid/s_ready     sample handshake (s_ready high only in RUN)
//   s_data              signed sample
//   enc_data/enc_stb    registered sample to encoder, one-cycle update strobe
//   enc_clr             one-cycle encoder clear on the first RUN cycle
//   enc_symbol          encoder alphabet symbol, qualified by enc_sym_valid
//   m_valid/m_ready     bin output handshake
//   m_bin/m_count       bin index and bin count
//   busy                high in any state except IDLE
//   done                one-cycle pulse after the final bin is accepted
//   sat_flag            (TESPAR_SAT_FLAG_EN only) saturation indicator
// -----------------------------------------------------------------------------
module tespar_frame_ctrl #(
  parameter int FRAME_LEN = 256,
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [7:0]       s_data,
  output logic signed [7:0]       enc_data,
  output logic                    enc_stb,
  output logic                    enc_clr,
  input  logic [4:0]              enc_symbol,
  input  logic                    enc_sym_valid,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [4:0]              m_bin,
  output logic [CNT_W-1:0]        m_count,
  output logic                    busy,
  output logic                    done
`ifdef TESPAR_SAT_FLAG_EN
  ,
  output logic                    sat_flag
`endif
);

  localparam int NUM_BINS = 32;
  localparam int SAMPLE_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int DRAIN_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DUMP
  } state_e;

  state_e                 state_q, state_d;
  logic [SAMPLE_W-1:0]    sample_cnt_q, sample_cnt_d;
  logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;
  logic [4:0]             dump_idx_q, dump_idx_d;
  logic [CNT_W-1:0]       bin_q [NUM_BINS];
  logic [CNT_W-1:0]       bin_d [NUM_BINS];

  logic                   s_ready_q, s_ready_d;
  logic signed [7:0]      enc_data_q, enc_data_d;
  logic                   enc_stb_q, enc_stb_d;
  logic                   enc_clr_q, enc_clr_d;
  logic                   m_valid_q, m_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   start_ok;
  logic                   sample_acc;
  logic                   count_en;
  logic                   dump_hs;
  logic                   bin_at_max;

  // done_q is high only in the first IDLE cycle after a dump; a start request
  // coincident with done is deliberately dropped.
  assign start_ok   = (state_q == ST_IDLE) && start && !done_q;
  assign sample_acc = s_ready_q && s_valid;
  assign count_en   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign dump_hs    = m_valid_q && m_ready;
  assign bin_at_max = (bin_q[enc_symbol] == CNT_MAX);

  // Next-state and registered-output decode.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    dump_idx_d   = dump_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d      = ST_RUN;
          sample_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (sample_acc) begin
          if (sample_cnt_q == SAMPLE_W'(FRAME_LEN - 1)) begin
            state_d      = ST_DRAIN;
            sample_cnt_d = '0;
            drain_cnt_d  = '0;
          end else begin
            sample_cnt_d = sample_cnt_q + SAMPLE_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_W'(DRAIN_CYC - 1)) begin
          state_d     = ST_DUMP;
          drain_cnt_d = '0;
          dump_idx_d  = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      ST_DUMP: begin
        if (dump_hs) begin
          // Index wraps 31 -> 0, leaving m_bin at 0 for the next frame.
          dump_idx_d = dump_idx_q + 5'd1;
          if (dump_idx_q == 5'd31) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    enc_data_d = sample_acc ? s_data : enc_data_q;
    enc_stb_d  = sample_acc;
    enc_clr_d  = start_ok;
    s_ready_d  = (state_d == ST_RUN);
    m_valid_d  = (state_d == ST_DUMP);
    busy_d     = (state_d != ST_IDLE);
    done_d     = dump_hs && (dump_idx_q == 5'd31);
  end

  // Bin update: counting only in RUN/DRAIN, clearing only on a DUMP handshake,
  // so the two never target the same cycle.
  always_comb begin
    bin_d = bin_q;
    if (count_en && enc_sym_valid && !bin_at_max) begin
      bin_d[enc_symbol] = bin_q[enc_symbol] + CNT_W'(1);
    end
    if (dump_hs) begin
      bin_d[dump_idx_q] = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sample_cnt_q <= '0;
      drain_cnt_q  <= '0;
      dump_idx_q   <= '0;
      s_ready_q    <= 1'b0;
      enc_data_q   <= '0;
      enc_stb_q    <= 1'b0;
      enc_clr_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      dump_idx_q   <= dump_idx_d;
      s_ready_q    <= s_ready_d;
      enc_data_q   <= enc_data_d;
      enc_stb_q    <= enc_stb_d;
      enc_clr_q    <= enc_clr_d;
      m_valid_q    <= m_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // NOTE: the bins are built from resettable flops rather than a RAM because a
  // reset mid-frame must return every bin to zero at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        bin_q[i] <= '0;
      end
    end else begin
      bin_q <= bin_d;
    end
  end

`ifdef TESPAR_SAT_FLAG_EN
  logic sat_flag_q, sat_flag_d;
  logic sat_hit;

  assign sat_hit = count_en && enc_sym_valid && bin_at_max;

  always_comb begin
    sat_flag_d = sat_flag_q | sat_hit;
    if (start_ok) begin
      sat_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag_q <= 1'b0;
    end else begin
      sat_flag_q <= sat_flag_d;
    end
  end

  assign sat_flag = sat_flag_q;
`endif

  assign s_ready  = s_ready_q;
  assign enc_data = enc_data_q;
  assign enc_stb  = enc_stb_q;
  assign enc_clr  = enc_clr_q;
  assign m_valid  = m_valid_q;
  assign m_bin    = dump_idx_q;
  assign m_count  = m_valid_q ? bin_q[dump_idx_q] : '0;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tespar_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tespar_frame_ctrl
//
// Directed self-checking bench for tespar_frame_ctrl with default parameters
// (FRAME_LEN=256, DRAIN_CYC=2, CNT_W=8). Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point, well before the next
// edge.
// -----------------------------------------------------------------------------
module tb_tespar_frame_ctrl;

  localparam int FRAME_LEN = 256;
  localparam int CNT_W     = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                s_valid;
  logic                s_ready;
  logic signed [7:0]   s_data;
  logic signed [7:0]   enc_data;
  logic                enc_stb;
  logic                enc_clr;
  logic [4:0]          enc_symbol;
  logic                enc_sym_valid;
  logic                m_valid;
  logic                m_ready;
  logic [4:0]          m_bin;
  logic [CNT_W-1:0]    m_count;
  logic                busy;
  logic                done;
`ifdef TESPAR_SAT_FLAG_EN
  logic                sat_flag;
`endif

  tespar_frame_ctrl #(
    .FRAME_LEN (FRAME_LEN),
    .DRAIN_CYC (2),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .enc_data      (enc_data),
    .enc_stb       (enc_stb),
    .enc_clr       (enc_clr),
    .enc_symbol    (enc_symbol),
    .enc_sym_valid (enc_sym_valid),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_bin         (m_bin),
    .m_count       (m_count),
    .busy          (busy),
    .done          (done)
`ifdef TESPAR_SAT_FLAG_EN
    ,
    .sat_flag      (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_bins [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks a whole dump. With stall=1, m_ready alternates 0/1 starting at 0, so
  // every bin is shown for one stalled cycle and one accepted cycle (64 cycles).
  // Symbol 20 is pulsed early in the dump; it must never reach a bin.
  task automatic dump_check(input bit stall);
    int ncyc;
    int k;
    ncyc = stall ? 64 : 32;
    for (int c = 0; c < ncyc; c++) begin
      k             = stall ? (c / 2) : c;
      m_ready       = stall ? ((c % 2) == 1) : 1'b1;
      enc_sym_valid = (c < 4);
      enc_symbol    = 5'd20;
      check($sformatf("m_valid c%0d", c), 32'(m_valid), 32'd1);
      check($sformatf("m_bin c%0d", c), 32'(m_bin), 32'(k));
      check($sformatf("m_count bin%0d c%0d", k, c), 32'(m_count), 32'(exp_bins[k]));
      check($sformatf("done early c%0d", c), 32'(done), 32'd0);
      tick();
    end
    enc_sym_valid = 1'b0;
    m_ready       = 1'b0;
    check("done after last bin", 32'(done), 32'd1);
    check("busy with done", 32'(busy), 32'd0);
    check("m_valid after dump", 32'(m_valid), 32'd0);
    check("m_bin after dump", 32'(m_bin), 32'd0);
  endtask

  initial begin
    int               n_acc;
    int               cyc;
    logic signed [7:0] last_data;

    reset         = 1'b1;
    start         = 1'b0;
    s_valid       = 1'b0;
    s_data        = '0;
    enc_symbol    = '0;
    enc_sym_valid = 1'b0;
    m_ready       = 1'b0;
    tick();
    tick();

    // Reset values.
    check("rst s_ready", 32'(s_ready), 32'd0);
    check("rst enc_data", 32'(enc_data), 32'd0);
    check("rst enc_stb", 32'(enc_stb), 32'd0);
    check("rst enc_clr", 32'(enc_clr), 32'd0);
    check("rst m_valid", 32'(m_valid), 32'd0);
    check("rst m_bin", 32'(m_bin), 32'd0);
    check("rst m_count", 32'(m_count), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
`ifdef TESPAR_SAT_FLAG_EN
    check("rst sat_flag", 32'(sat_flag), 32'd0);
`endif
    reset = 1'b0;
    tick();

    // Aborted frame: 10 samples plus symbol 9, then asynchronous reset.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort s_ready", 32'(s_ready), 32'd1);
    check("abort enc_clr", 32'(enc_clr), 32'd1);
    check("abort busy", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      s_valid       = 1'b1;
      s_data        = 8'(i + 1);
      enc_sym_valid = 1'b1;
      enc_symbol    = 5'd9;
      tick();
    end
    check("abort enc_stb", 32'(enc_stb), 32'd1);
    reset = 1'b1;
    #2;
    check("midrun rst s_ready", 32'(s_ready), 32'd0);
    check("midrun rst enc_data", 32'(enc_data), 32'd0);
    check("midrun rst enc_stb", 32'(enc_stb), 32'd0);
    check("midrun rst busy", 32'(busy), 32'd0);
    check("midrun rst m_valid", 32'(m_valid), 32'd0);
    s_valid       = 1'b0;
    enc_sym_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Frame 1: continuous samples; symbol 5 on 100 RUN cycles, symbol 31 on
    // one RUN cycle and both DRAIN cycles.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("f1 enc_clr", 32'(enc_clr), 32'd1);
    check("f1 s_ready", 32'(s_ready), 32'd1);
    n_acc     = 0;
    cyc       = 0;
    last_data = '0;
    while (s_ready && cyc < 400) begin
      s_valid       = 1'b1;
      s_data        = 8'(cyc * 37 + 5);
      enc_sym_valid = (cyc < 100) || (cyc == 200);
      enc_symbol    = (cyc < 100) ? 5'd5 : 5'd31;
      last_data     = s_data;
      n_acc++;
      cyc++;
      tick();
      if (cyc == 1) begin
        check("f1 enc_clr one cycle", 32'(enc_clr), 32'd0);
        check("f1 first enc_stb", 32'(enc_stb), 32'd1);
        check("f1 first enc_data", 32'(enc_data), 32'(last_data));
      end
      if (cyc == 128) begin
        check("f1 mid enc_data", 32'(enc_data), 32'(last_data));
      end
    end
    check("f1 samples accepted", 32'(n_acc), 32'(FRAME_LEN));
    check("f1 last enc_stb", 32'(enc_stb), 32'd1);
    check("f1 last enc_data", 32'(enc_data), 32'(last_data));

    // DRAIN cycle 1: s_valid still high, start requested (must be ignored).
    enc_sym_valid = 1'b1;
    enc_symbol    = 5'd31;
    start         = 1'b1;
    check("drain busy", 32'(busy), 32'd1);
    check("drain m_valid early", 32'(m_valid), 32'd0);
    tick();
    start = 1'b0;
    check("drain no extra sample", 32'(enc_stb), 32'd0);
    check("drain start ignored", 32'(enc_clr), 32'd0);
    check("drain s_ready", 32'(s_ready), 32'd0);
    check("drain m_valid early 2", 32'(m_valid), 32'd0);
    enc_sym_valid = 1'b1;
    enc_symbol    = 5'd31;
    tick();
    s_valid       = 1'b0;
    enc_sym_valid = 1'b0;
    check("last sample to m_valid", 32'(m_valid), 32'd1);

    for (int i = 0; i < 32; i++) exp_bins[i] = 0;
    exp_bins[5]  = 100;
    exp_bins[31] = 3;
    dump_check(1'b0);

    // Start on the done cycle must be ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start on done ignored busy", 32'(busy), 32'd0);
    check("start on done ignored clr", 32'(enc_clr), 32'd0);
    check("done one cycle", 32'(done), 32'd0);

    // Symbols in IDLE must not count.
    enc_sym_valid = 1'b1;
    enc_symbol    = 5'd3;
    tick();
    tick();
    tick();
    enc_sym_valid = 1'b0;
    check("idle s_ready", 32'(s_ready), 32'd0);

    // Frame 2: 50 idle RUN cycles then 256 samples; symbol 7 on the first 300
    // RUN cycles saturates bin 7 at 255.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("f2 busy", 32'(busy), 32'd1);
    check("f2 enc_clr", 32'(enc_clr), 32'd1);
`ifdef TESPAR_SAT_FLAG_EN
    check("f2 sat_flag cleared", 32'(sat_flag), 32'd0);
`endif
    n_acc = 0;
    cyc   = 0;
    while (s_ready && cyc < 600) begin
      s_valid       = (cyc >= 50);
      s_data        = 8'(cyc);
      enc_sym_valid = (cyc < 300);
      enc_symbol    = 5'd7;
      if (s_valid) n_acc++;
      cyc++;
      tick();
      if (cyc == 50) begin
        check("f2 no stb while idle", 32'(enc_stb), 32'd0);
      end
    end
    s_valid       = 1'b0;
    enc_sym_valid = 1'b0;
    check("f2 samples accepted", 32'(n_acc), 32'(FRAME_LEN));
    check("f2 run cycles", 32'(cyc), 32'd306);
    tick();
    tick();
    check("f2 m_valid", 32'(m_valid), 32'd1);

    for (int i = 0; i < 32; i++) exp_bins[i] = 0;
    exp_bins[7] = 255;
    dump_check(1'b1);
`ifdef TESPAR_SAT_FLAG_EN
    check("sat_flag at done", 32'(sat_flag), 32'd1);
`endif
    tick();
    check("f2 done one cycle", 32'(done), 32'd0);
`ifdef TESPAR_SAT_FLAG_EN
    check("sat_flag held in idle", 32'(sat_flag), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
